// File: rtl/windowed_regfile_le_aclr_pkg.sv
// Shared constants and logical-to-physical register mapping for the windowed register file.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package windowed_regfile_le_aclr_pkg;

  // Register-file geometry
  localparam int unsigned GLOBALS  = 8;
  localparam int unsigned WINREGS  = 16;

  // Logical region bounds inside r0..r31
  localparam int unsigned OUT_BASE = 8;
  localparam int unsigned LOC_BASE = 16;
  localparam int unsigned IN_BASE  = 24;

  // Window rotate request, encoded as {save, restore}
  typedef enum logic [1:0] {
    ROT_NONE    = 2'b00,
    ROT_RESTORE = 2'b01,
    ROT_SAVE    = 2'b10,
    ROT_BOTH    = 2'b11
  } rot_e;

  // Physical slot of logical register r under window pointer cwp.
  // Globals occupy slots 0..7; windowed registers follow and wrap modulo
  // the windowed pool, so the ins of window w-1 land on the outs of window w.
  function automatic int unsigned phys_idx(input logic [4:0] r,
                                           input int unsigned cwp,
                                           input int unsigned nwin);
    int unsigned ri;
    ri = 32'(r);
    if (ri < OUT_BASE) begin
      return ri;
    end
    return GLOBALS + ((cwp * WINREGS + ri - OUT_BASE) % (WINREGS * nwin));
  endfunction

endpackage

// File: rtl/register_nbit_le_aclr.sv
// WIDTH-bit register with load enable and asynchronous active-low clear.
// Latency: new value visible one cycle after a loaded edge.
// Backpressure: none; holds its value while the load enable is low.
module register_nbit_le_aclr #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_load_e,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Capture the input on enabled edges; clear immediately while i_clr is low
  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_q <= '0;
    end else if (i_load_e) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/windowed_regfile_le_aclr.sv
// SPARC-style windowed integer register file: 8 globals + NWINDOWS overlapping 16-reg windows, CWP/WIM, window traps.
// Latency: reads combinational; writes, CWP/WIM updates and trap/error pulses take effect at the next edge.
// Backpressure: none; an overflowing/underflowing/conflicting rotate suppresses the write. Optional: REGFILE_BYPASS_EN forwards the write data to reads.
module windowed_regfile_le_aclr
  import windowed_regfile_le_aclr_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NWINDOWS = 8,
  parameter int CWPW     = $clog2(NWINDOWS)
) (
  input  logic                i_clk,
  input  logic                i_clr,
  input  logic [4:0]          i_rs1,
  input  logic [4:0]          i_rs2,
  output logic [WIDTH-1:0]    o_rd1_data,
  output logic [WIDTH-1:0]    o_rd2_data,
  input  logic [4:0]          i_rd,
  input  logic [WIDTH-1:0]    i_wr_data,
  input  logic                i_load_e,
  input  logic                i_save,
  input  logic                i_restore,
  input  logic                i_cwp_we,
  input  logic [CWPW-1:0]     i_cwp_in,
  input  logic                i_wim_we,
  input  logic [NWINDOWS-1:0] i_wim_in,
  output logic [CWPW-1:0]     o_cwp,
  output logic [NWINDOWS-1:0] o_wim,
  output logic                o_win_ovf,
  output logic                o_win_unf,
  output logic                o_op_err
);

  localparam int NPHYS = int'(GLOBALS + WINREGS * NWINDOWS);
  localparam int PW    = $clog2(NPHYS);

  logic [CWPW-1:0]     r_cwp;
  logic [NWINDOWS-1:0] r_wim;
  logic                r_ovf;
  logic                r_unf;
  logic                r_err;

  rot_e                w_rot;
  logic [CWPW-1:0]     w_save_tgt;
  logic [CWPW-1:0]     w_rest_tgt;
  logic [CWPW-1:0]     w_cwp_nxt;
  logic [CWPW-1:0]     w_cwp_map;
  logic                w_wr_blk;
  logic                w_ovf;
  logic                w_unf;
  logic                w_err;
  logic                w_wr_ok;
  logic [PW-1:0]       w_wr_pidx;
  logic [PW-1:0]       w_rs1_pidx;
  logic [PW-1:0]       w_rs2_pidx;
  logic [WIDTH-1:0]    w_q [NPHYS];

  assign w_rot      = rot_e'({i_save, i_restore});
  // Neighbouring windows with wrap-around; NWINDOWS need not be a power of two
  assign w_save_tgt = (r_cwp == '0) ? CWPW'(NWINDOWS - 1) : r_cwp - CWPW'(1);
  assign w_rest_tgt = (r_cwp == CWPW'(NWINDOWS - 1)) ? '0 : r_cwp + CWPW'(1);

  // Resolve the CWP update, the window used to map rd, and any trap/error this cycle
  always_comb begin
    w_cwp_nxt = r_cwp;
    w_cwp_map = r_cwp;
    w_wr_blk  = 1'b0;
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    w_err     = 1'b0;
    if (i_cwp_we) begin
      // Trap-handler load wins outright; a write this cycle still uses the old window
      w_cwp_nxt = i_cwp_in;
    end else begin
      case (w_rot)
        ROT_SAVE: begin
          if (r_wim[w_save_tgt]) begin
            w_ovf    = 1'b1;
            w_wr_blk = 1'b1;
          end else begin
            w_cwp_nxt = w_save_tgt;
            w_cwp_map = w_save_tgt;
          end
        end
        ROT_RESTORE: begin
          if (r_wim[w_rest_tgt]) begin
            w_unf    = 1'b1;
            w_wr_blk = 1'b1;
          end else begin
            w_cwp_nxt = w_rest_tgt;
            w_cwp_map = w_rest_tgt;
          end
        end
        ROT_BOTH: begin
          w_err    = 1'b1;
          w_wr_blk = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_wr_ok    = i_load_e && !w_wr_blk && (i_rd != 5'd0);
  assign w_wr_pidx  = PW'(phys_idx(i_rd,  32'(w_cwp_map), NWINDOWS));
  assign w_rs1_pidx = PW'(phys_idx(i_rs1, 32'(r_cwp),     NWINDOWS));
  assign w_rs2_pidx = PW'(phys_idx(i_rs2, 32'(r_cwp),     NWINDOWS));

  for (genvar g = 0; g < NPHYS; g++) begin : g_phys
    logic w_we;
    assign w_we = w_wr_ok && (w_wr_pidx == PW'(g));
    register_nbit_le_aclr #(.WIDTH(WIDTH)) u_reg (
      .i_clk    (i_clk),
      .i_clr    (i_clr),
      .i_load_e (w_we),
      .i_d      (i_wr_data),
      .o_q      (w_q[g])
    );
  end

  // Combinational read ports; r0 is hard-wired to zero
  always_comb begin
    o_rd1_data = (i_rs1 == 5'd0) ? '0 : w_q[w_rs1_pidx];
    o_rd2_data = (i_rs2 == 5'd0) ? '0 : w_q[w_rs2_pidx];
`ifdef REGFILE_BYPASS_EN
    // Forward on physical match so aliased in/out registers see the new value too
    if (w_wr_ok && (i_rs1 != 5'd0) && (w_wr_pidx == w_rs1_pidx)) o_rd1_data = i_wr_data;
    if (w_wr_ok && (i_rs2 != 5'd0) && (w_wr_pidx == w_rs2_pidx)) o_rd2_data = i_wr_data;
`endif
  end

  // Window state and single-cycle trap/error flags
  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_cwp <= '0;
      r_wim <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_cwp <= w_cwp_nxt;
      if (i_wim_we) r_wim <= i_wim_in;
      r_ovf <= w_ovf;
      r_unf <= w_unf;
      r_err <= w_err;
    end
  end

  assign o_cwp     = r_cwp;
  assign o_wim     = r_wim;
  assign o_win_ovf = r_ovf;
  assign o_win_unf = r_unf;
  assign o_op_err  = r_err;

endmodule

// File: tb/tb_windowed_regfile_le_aclr.sv
// Directed self-checking bench for windowed_regfile_le_aclr (WIDTH=32, NWINDOWS=8).
// Latency: checks reads combinationally and state one clock after each step.
// Backpressure: n/a.
module tb_windowed_regfile_le_aclr;

  logic        clk;
  logic        clr;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rd1_data, rd2_data, wr_data;
  logic        load_e, save, restore, cwp_we, wim_we;
  logic [2:0]  cwp_in, cwp;
  logic [7:0]  wim_in, wim;
  logic        win_ovf, win_unf, op_err;

  int n_checks = 0;
  int n_fails  = 0;

  windowed_regfile_le_aclr #(.WIDTH(32), .NWINDOWS(8)) dut (
    .i_clk(clk), .i_clr(clr),
    .i_rs1(rs1), .i_rs2(rs2),
    .o_rd1_data(rd1_data), .o_rd2_data(rd2_data),
    .i_rd(rd), .i_wr_data(wr_data), .i_load_e(load_e),
    .i_save(save), .i_restore(restore),
    .i_cwp_we(cwp_we), .i_cwp_in(cwp_in),
    .i_wim_we(wim_we), .i_wim_in(wim_in),
    .o_cwp(cwp), .o_wim(wim),
    .o_win_ovf(win_ovf), .o_win_unf(win_unf), .o_op_err(op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then return all request strobes to idle away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
    load_e = 0; save = 0; restore = 0; cwp_we = 0; wim_we = 0;
  endtask

  task automatic set_cwp(input logic [2:0] v);
    cwp_we = 1; cwp_in = v;
    tick();
  endtask

  initial begin
    logic [31:0] exp_byp;
    clr = 0; rs1 = 0; rs2 = 0; rd = 0; wr_data = 0;
    load_e = 0; save = 0; restore = 0; cwp_we = 0; cwp_in = 0; wim_we = 0; wim_in = 0;
    #12;
    // Reset state
    rs1 = 5'd9; rs2 = 5'd31;
    #1;
    check("reset_cwp", 32'(cwp), 32'd0);
    check("reset_wim", 32'(wim), 32'd0);
    check("reset_flags", {29'd0, win_ovf, win_unf, op_err}, 32'd0);
    check("reset_rd1", rd1_data, 32'd0);
    clr = 1;
    #10;

    // Async clear mid-cycle wipes registers, cwp and wim at once
    cwp_we = 1; cwp_in = 3'd3; wim_we = 1; wim_in = 8'h01;
    tick();
    load_e = 1; rd = 5'd9; wr_data = 32'hDEADBEEF;
    tick();
    check("pre_clr_r9", rd1_data, 32'hDEADBEEF);
    check("pre_clr_cwp", 32'(cwp), 32'd3);
    #2 clr = 0;
    #1;
    check("clr_r9", rd1_data, 32'd0);
    check("clr_cwp", 32'(cwp), 32'd0);
    check("clr_wim", 32'(wim), 32'd0);
    #1 clr = 1;
    tick();

    // Window overlap: out0 of window 3 is in0 of window 2
    set_cwp(3'd3);
    load_e = 1; rd = 5'd8; wr_data = 32'h11111111;
    tick();
    save = 1;
    tick();
    rs1 = 5'd24;
    #1;
    check("ovl_save_cwp", 32'(cwp), 32'd2);
    check("ovl_r24", rd1_data, 32'h11111111);
    restore = 1;
    tick();
    rs1 = 5'd8;
    #1;
    check("ovl_rest_cwp", 32'(cwp), 32'd3);
    check("ovl_r8", rd1_data, 32'h11111111);

    // Wrap-around and r0
    set_cwp(3'd0);
    save = 1;
    tick();
    check("wrap_save_cwp", 32'(cwp), 32'd7);
    check("wrap_no_ovf", 32'(win_ovf), 32'd0);
    restore = 1;
    tick();
    check("wrap_rest_cwp", 32'(cwp), 32'd0);
    load_e = 1; rd = 5'd0; wr_data = 32'h5; rs1 = 5'd0;
    #1;
    check("r0_same_cycle", rd1_data, 32'd0);
    tick();
    check("r0_after", rd1_data, 32'd0);

    // Overflow: save into an invalid window is refused along with its write
    wim_we = 1; wim_in = 8'h04; cwp_we = 1; cwp_in = 3'd3;
    tick();
    save = 1; load_e = 1; rd = 5'd16; wr_data = 32'hCAFEF00D; rs1 = 5'd16;
    tick();
    check("ovf_cwp", 32'(cwp), 32'd3);
    check("ovf_pulse", 32'(win_ovf), 32'd1);
    check("ovf_no_write", rd1_data, 32'd0);
    tick();
    check("ovf_one_cycle", 32'(win_ovf), 32'd0);

    // Underflow
    wim_we = 1; wim_in = 8'h10;
    tick();
    restore = 1;
    tick();
    check("unf_cwp", 32'(cwp), 32'd3);
    check("unf_pulse", 32'(win_unf), 32'd1);
    tick();
    check("unf_one_cycle", 32'(win_unf), 32'd0);

    // WIM load and save in the same cycle: trap check sees the old mask (bit 2 clear)
    wim_we = 1; wim_in = 8'h04; save = 1;
    tick();
    check("wim_old_cwp", 32'(cwp), 32'd2);
    check("wim_old_no_ovf", 32'(win_ovf), 32'd0);
    check("wim_loaded", 32'(wim), 32'h04);

    // Same-cycle save and write: rd maps through the new window
    wim_we = 1; wim_in = 8'h00; cwp_we = 1; cwp_in = 3'd5;
    tick();
    save = 1; load_e = 1; rd = 5'd16; wr_data = 32'hA5A5A5A5; rs1 = 5'd16;
    tick();
    check("rotwr_cwp", 32'(cwp), 32'd4);
    check("rotwr_r16", rd1_data, 32'hA5A5A5A5);
    restore = 1;
    tick();
    check("rotwr_rest_cwp", 32'(cwp), 32'd5);
    check("rotwr_r16_w5", rd1_data, 32'd0);

    // save and restore together: no rotate, no write, error pulse
    save = 1; restore = 1; load_e = 1; rd = 5'd17; wr_data = 32'h77; rs1 = 5'd17;
    tick();
    check("err_pulse", 32'(op_err), 32'd1);
    check("err_cwp", 32'(cwp), 32'd5);
    check("err_no_write", rd1_data, 32'd0);
    tick();
    check("err_one_cycle", 32'(op_err), 32'd0);

    // Direct CWP load with a write: write maps through the old window (5)
    cwp_we = 1; cwp_in = 3'd1; load_e = 1; rd = 5'd16; wr_data = 32'hBEEF0001;
    tick();
    check("cwpwe_cwp", 32'(cwp), 32'd1);
    set_cwp(3'd5);
    rs1 = 5'd16;
    #1;
    check("cwpwe_old_map", rd1_data, 32'hBEEF0001);

    // Write/read of the same register in one cycle
    load_e = 1; rd = 5'd12; wr_data = 32'h12345678; rs1 = 5'd12; rs2 = 5'd12;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_byp = 32'h12345678;
`else
    exp_byp = 32'd0;
`endif
    check("byp_rd1", rd1_data, exp_byp);
    check("byp_rd2", rd2_data, exp_byp);
    tick();
    check("byp_after", rd1_data, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/windowed_regfile_le_aclr.md
Name: windowed_regfile_le_aclr

Overview:
- Parametrised successor of the 32-bit load-enable/async-clear register: a SPARC-style windowed integer register file.
- 8 globals plus NWINDOWS overlapping 16-register windows; 2 combinational read ports, 1 clocked write port.
- Holds Current Window Pointer (CWP) and Window Invalid Mask (WIM); signals window overflow/underflow traps.
- Sits between decode (operand read) and writeback in the integer pipeline.

Parameters:
- WIDTH, 32, data width of every register
- NWINDOWS, 8, number of register windows (legal 2..32)
- CWPW, $clog2(NWINDOWS), width of CWP

Ports:
- Clk  in  1  clock, rising edge
- Clr  in  1  asynchronous active-low reset; clears all state while low
- rs1, rs2  in  5  logical read addresses
- rd1_data, rd2_data  out  WIDTH  read data
- rd  in  5  logical write address
- wr_data  in  WIDTH  write data
- loadE  in  1  write enable
- save, restore  in  1  window rotate requests
- cwp_we  in  1  direct CWP load (trap handler)
- cwp_in  in  CWPW  value for cwp_we
- wim_we  in  1  WIM load enable
- wim_in  in  NWINDOWS  value for wim_we
- cwp  out  CWPW  current window pointer
- wim  out  NWINDOWS  current WIM
- win_ovf, win_unf  out  1  one-cycle trap pulses
- op_err  out  1  one-cycle pulse: save and restore asserted together

Behaviour:
- Reset (Clr low, async): all physical registers 0, cwp=0, wim=0, win_ovf=win_unf=op_err=0. Reset mid-operation overrides any write/rotate in flight.
- Physical array: 8 globals + 16*NWINDOWS windowed registers.
- Mapping: r0..r7 -> global[r]; r8..r31 -> win[(cwp*16 + (r-8)) mod (16*NWINDOWS)]. Ins of window w-1 alias outs of window w.
- r0 reads 0 always; writes to r0 discarded.
- Reads combinational, using the current (registered) cwp.
- save: target = (cwp-1) mod NWINDOWS. If wim[target]=1, cwp unchanged, no write, win_ovf=1 next cycle. Otherwise cwp<=target.
- restore: target = (cwp+1) mod NWINDOWS. If wim[target]=1, cwp unchanged, no write, win_unf=1 next cycle. Otherwise cwp<=target.
- Wrap-around: cwp 0 on save -> NWINDOWS-1; cwp NWINDOWS-1 on restore -> 0.
- Write with successful rotate in the same cycle: rd is mapped using the NEW cwp (SPARC SAVE/RESTORE semantics). Otherwise rd is mapped using the current cwp.
- save & restore together: neither rotates, write suppressed, op_err=1 next cycle.
- Priority for CWP: cwp_we > save/restore. cwp_we takes effect without a trap check; a loadE write in that cycle uses the old cwp.
- wim_we updates wim at the edge. A trap check in the same cycle uses the old wim.
- Trap and error flags are high for exactly one cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: if loadE is high and the physical index of rd (after mapping) equals that of rs1/rs2, rdN_data returns wr_data in the same cycle. Physical-index compare, so aliased out/in registers forward. Never for r0 or a suppressed write.
- Undefined: reads return the stored value; the new value is visible the cycle after the edge.

Decomposition:
- Shared include file: GLOBALS=8, WINREGS=16, logical region bounds (OUT_BASE=8, LOC_BASE=16, IN_BASE=24), physical-index function.
- Sub-module: register_nbit_le_aclr (WIDTH parameter, loadE, active-low async Clr), instantiated per physical register.

Test Plan:
- Reset: write r9=0xDEADBEEF, pulse Clr low mid-cycle -> r9 reads 0 immediately, cwp=0, wim=0.
- Overlap: cwp=3, write r8 (out0)=0x11111111, save -> cwp=2, r24 (in0) reads 0x11111111. Restore -> cwp=3, r8 reads 0x11111111.
- Wrap: cwp=0, save -> cwp=7; restore -> cwp=0; r0 write 0x5 -> r0 still reads 0.
- Overflow: wim=8'h04, cwp=3, save with loadE rd=r16 -> cwp stays 3, no write, win_ovf high for 1 cycle. Restore with wim=8'h10 -> win_unf.
- Same-cycle rotate+write: cwp=5, save, loadE, rd=r16, data 0xA5A5A5A5 -> after edge cwp=4 and r16 reads 0xA5A5A5A5. Restore -> cwp=5, r16 differs. save+restore together -> op_err pulse, cwp unchanged.
- Bypass (REGFILE_BYPASS_EN): loadE rd=r12 data 0x12345678, rs1=r12 same cycle -> rd1_data=0x12345678 before the edge; without macro -> old value.
